config_chain: RTL and testbench
===============================

// Module: config_chain
// PURPOSE
//  Serial-loaded configuration store with a shadow shift register and an atomic, handshaked commit.
//  Bits shift into the shadow without disturbing the live config.
//  A latch pulse checks frame length (and optionally parity), then waits for applyReady from the
//  consuming datapath before the live config is updated in a single cycle.
//  Sits between the chip-level serial config port and the clock divider / filter-coefficient logic.
//  serialOut allows daisy-chaining several instances.
// PARAMETERS
//  ConfigWidth   5      live config width in bits (>=2)
//  DefaultConfig 5'h1F  value of shadow and live config after reset
//  FrameLen      local  ConfigWidth, or ConfigWidth+1 when CONFIG_PARITY_EN is defined
//  CountWidth    local  $clog2(FrameLen+2); bit counter width
// PORTS
//  clk         in   1            system clock, all state on rising edge
//  reset       in   1            synchronous, active-high
//  serialEn    in   1            shift enable: one bit accepted per cycle
//  serialIn    in   1            serial data, MSB first
//  serialOut   out  1            shadow register MSB (daisy-chain output)
//  latch       in   1            request commit of shifted frame
//  applyReady  in   1            consumer indicates it is safe to swap config now
//  config      out  ConfigWidth  live configuration
//  updated     out  1            1-cycle pulse: config changed this cycle
//  frameError  out  1            1-cycle pulse: latch rejected
//  busy        out  1            high while commit is pending
// BEHAVIOUR
//  Reset
//   - shadow=DefaultConfig (parity bit=0 if enabled); config=DefaultConfig; count=0; state=IDLE.
//   - updated=0, frameError=0, busy=0; serialOut=DefaultConfig[MSB].
//   - Reset in any state, including PENDING, aborts the commit; no updated pulse.
//  States
//   IDLE
//    - serialEn: shadow<={shadow[FrameLen-2:0],serialIn}; count<=1; go SHIFT.
//   SHIFT
//    - serialEn: shift; count increments, saturating at FrameLen+1 (overflow marker).
//   IDLE/SHIFT, on latch
//    - Accept when count==FrameLen and parity ok: go PENDING.
//    - Otherwise reject: frameError=1 next cycle; shadow<=active (with parity bit=^active);
//      count<=0; go IDLE.
//    - latch with count==0 is a reject.
//    - latch has priority: serialEn in the same cycle is ignored (bit dropped).
//   PENDING
//    - busy=1; serialEn and latch ignored.
//    - applyReady: config<=shadow data bits; updated=1 next cycle; count<=0; go IDLE.
//  Latency
//   - latch@N -> PENDING@N+1.
//   - applyReady sampled from N+1; earliest config/updated at N+2.
//   - applyReady during IDLE/SHIFT has no effect.
//  Outputs
//   - updated, frameError: registered, never high together, never >1 cycle.
//   - serialOut: combinational from shadow MSB, changes only on a shift or a reject reload.
// CONFIGURATION
//  CONFIG_PARITY_EN defined
//   - Shadow is ConfigWidth+1 bits: data=[FrameLen-1:1], parity=[0], the last bit shifted in.
//   - Accept requires ^shadow==0 (even parity over data+parity bits).
//  CONFIG_PARITY_EN undefined
//   - Shadow is ConfigWidth bits; frame accepted on length alone; no parity logic.
// STRUCTURE
//  Package config_chain_pkg
//   - typedef enum logic [1:0] {IDLE,SHIFT,PENDING} config_state_e.
//   - function frame_len(width, parityEn).
//  Sub-module config_shadow_sreg
//   - Shadow register, saturating bit counter, reload port, length/parity-ok flags.
//  Top
//   - FSM, live register, pulse outputs.
// TESTING (ConfigWidth=5, DefaultConfig=5'h1F, parity off unless stated)
//  1. Reset
//     - Hold reset 2 cycles -> config=5'h1F, serialOut=1, busy/updated/frameError=0.
//  2. Normal frame
//     - Shift 1,0,1,0,0 (5'h14); latch@N; applyReady high from N+1
//       -> config=5'h14 and updated=1 at N+2 only; busy high at N+1.
//  3. Short/long frame
//     - Shift 4 bits, latch -> frameError pulse, config stays 5'h1F, shadow reloaded (serialOut=1).
//     - Repeat with 7 bits -> same.
//  4. Deferred apply
//     - Valid 5'h0A frame, applyReady low 10 cycles, serialEn/latch toggled meanwhile
//       -> config unchanged, shadow unchanged.
//     - applyReady@M -> config=5'h0A at M+1.
//  5. Reset mid-PENDING
//     - Reset while busy -> config=5'h1F, no updated pulse.
//  6. Parity (CONFIG_PARITY_EN)
//     - Frame 5'h14 + parity 0 -> accepted.
//     - 5'h14 + parity 1 -> frameError, config unchanged.

Source files
------------

// File: rtl/config_chain_pkg.sv
// Shared types and helpers for the serial configuration chain.
// Parity support is selected at build time with CONFIG_PARITY_EN.
package config_chain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PENDING
    } config_state_e;

`ifdef CONFIG_PARITY_EN
    localparam bit ParityEn = 1'b1;
`else
    localparam bit ParityEn = 1'b0;
`endif

    // Frame carries one trailing parity bit when parity is enabled.
    function automatic int frame_len(input int width, input bit parityEn);
        return parityEn ? width + 1 : width;
    endfunction

endpackage

// File: rtl/config_shadow_sreg.sv
// Shadow shift register for the config chain: MSB-first shift, saturating
// bit counter, reload from the live config, and length/parity-ok flags.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   shift_i, bit_i   shift one bit in (bit_i lands in the LSB)
//   reload_i         load reload_data_i (plus its parity) and clear count
//   reload_data_i    live config used on a rejected frame
//   clear_i          clear the bit counter after a commit
//   data_o           data bits of the shadow
//   msb_o            shadow MSB, daisy-chain output
//   len_ok_o         exactly one frame of bits has been shifted
//   parity_ok_o      even parity over data+parity (always 1 without parity)
// Build option: CONFIG_PARITY_EN adds a parity bit at shadow[0].
module config_shadow_sreg
    import config_chain_pkg::*;
#(
    parameter int                     ConfigWidth   = 5,
    parameter logic [ConfigWidth-1:0] DefaultConfig = 5'h1F,
    parameter int                     FrameLen      = 5,
    parameter int                     CountWidth    = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   shift_i,
    input  logic                   bit_i,
    input  logic                   reload_i,
    input  logic [ConfigWidth-1:0] reload_data_i,
    input  logic                   clear_i,
    output logic [ConfigWidth-1:0] data_o,
    output logic                   msb_o,
    output logic                   len_ok_o,
    output logic                   parity_ok_o
);

    // One count past a full frame marks an overlong frame.
    localparam logic [CountWidth-1:0] CntFull = CountWidth'(FrameLen);
    localparam logic [CountWidth-1:0] CntMax  = CountWidth'(FrameLen + 1);

`ifdef CONFIG_PARITY_EN
    localparam logic [FrameLen-1:0] ResetFrame = {DefaultConfig, 1'b0};
`else
    localparam logic [FrameLen-1:0] ResetFrame = DefaultConfig;
`endif

    logic [FrameLen-1:0]   shadow_q;
    logic [FrameLen-1:0]   shadow_d;
    logic [CountWidth-1:0] cnt_q;
    logic [CountWidth-1:0] cnt_d;
    logic [FrameLen-1:0]   reload_frame;

`ifdef CONFIG_PARITY_EN
    assign reload_frame = {reload_data_i, ^reload_data_i};
    assign parity_ok_o  = ~(^shadow_q);
`else
    assign reload_frame = reload_data_i;
    assign parity_ok_o  = 1'b1;
`endif

    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (reload_i) begin
            shadow_d = reload_frame;
            cnt_d    = '0;
        end else if (shift_i) begin
            shadow_d = {shadow_q[FrameLen-2:0], bit_i};
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CountWidth'(1);
            end
        end else if (clear_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_q <= ResetFrame;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_o   = shadow_q[FrameLen-1 -: ConfigWidth];
    assign msb_o    = shadow_q[FrameLen-1];
    assign len_ok_o = (cnt_q == CntFull);

endmodule

// File: rtl/config_chain.sv
// Serial-loaded configuration store: bits shift into a shadow register and
// a latch request commits them atomically once the consumer is ready.
// Ports:
//   clk_i, reset_i    clock, synchronous active-high reset
//   serialEn_i        accept one serial bit this cycle
//   serialIn_i        serial data, MSB first
//   serialOut_o       shadow MSB, for daisy-chaining
//   latch_i           request commit of the shifted frame
//   applyReady_i      consumer can take the new config now
//   config_o          live configuration
//   updated_o         1-cycle pulse, config changed
//   frameError_o      1-cycle pulse, latch rejected
//   busy_o            commit pending
// Build option: CONFIG_PARITY_EN appends an even-parity bit to each frame.
module config_chain
    import config_chain_pkg::*;
#(
    parameter int                     ConfigWidth   = 5,
    parameter logic [ConfigWidth-1:0] DefaultConfig = 5'h1F
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   serialEn_i,
    input  logic                   serialIn_i,
    output logic                   serialOut_o,
    input  logic                   latch_i,
    input  logic                   applyReady_i,
    output logic [ConfigWidth-1:0] config_o,
    output logic                   updated_o,
    output logic                   frameError_o,
    output logic                   busy_o
);

    localparam int FrameLen   = frame_len(ConfigWidth, ParityEn);
    localparam int CountWidth = $clog2(FrameLen + 2);

    config_state_e          state_q;
    logic [ConfigWidth-1:0] config_q;
    logic                   updated_q;
    logic                   frame_error_q;
    logic                   busy_q;

    logic [ConfigWidth-1:0] shadow_data;
    logic                   len_ok;
    logic                   parity_ok;
    logic                   accept;
    logic                   loading;
    logic                   shift_en;
    logic                   reload_en;
    logic                   clear_en;

    assign accept  = len_ok & parity_ok;
    assign loading = (state_q != PENDING);

    // Latch wins over a same-cycle shift; the shadow is frozen while pending.
    assign shift_en  = loading & serialEn_i & ~latch_i;
    assign reload_en = loading & latch_i & ~accept;
    assign clear_en  = (state_q == PENDING) & applyReady_i;

    config_shadow_sreg #(
        .ConfigWidth  (ConfigWidth),
        .DefaultConfig(DefaultConfig),
        .FrameLen     (FrameLen),
        .CountWidth   (CountWidth)
    ) u_shadow (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .shift_i      (shift_en),
        .bit_i        (serialIn_i),
        .reload_i     (reload_en),
        .reload_data_i(config_q),
        .clear_i      (clear_en),
        .data_o       (shadow_data),
        .msb_o        (serialOut_o),
        .len_ok_o     (len_ok),
        .parity_ok_o  (parity_ok)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            config_q      <= DefaultConfig;
            updated_q     <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            updated_q     <= 1'b0;
            frame_error_q <= 1'b0;
            unique case (state_q)
                IDLE, SHIFT: begin
                    if (latch_i) begin
                        if (accept) begin
                            state_q <= PENDING;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q       <= IDLE;
                            frame_error_q <= 1'b1;
                        end
                    end else if (serialEn_i) begin
                        state_q <= SHIFT;
                    end
                end
                PENDING: begin
                    if (applyReady_i) begin
                        config_q  <= shadow_data;
                        updated_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign config_o     = config_q;
    assign updated_o    = updated_q;
    assign frameError_o = frame_error_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_config_chain.sv
// Directed bench for config_chain: table of frames plus hand-written
// sequences for deferred apply and reset during a pending commit.
module tb_config_chain;

`ifdef CONFIG_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FL  = 6;
`else
    localparam bit PAR = 1'b0;
    localparam int FL  = 5;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serialEn = 1'b0;
    logic       serialIn = 1'b0;
    logic       latch = 1'b0;
    logic       applyReady = 1'b0;
    logic       serialOut;
    logic [4:0] cfg;
    logic       updated;
    logic       frameError;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    config_chain dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .serialEn_i  (serialEn),
        .serialIn_i  (serialIn),
        .serialOut_o (serialOut),
        .latch_i     (latch),
        .applyReady_i(applyReady),
        .config_o    (cfg),
        .updated_o   (updated),
        .frameError_o(frameError),
        .busy_o      (busy)
    );

    typedef struct {
        logic [4:0] data;
        int         delta;
        bit         badpar;
        bit         exp_ok;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic shift_frame(input logic [4:0] d, input int delta,
                               input bit badpar);
        logic [5:0] bits;
        int n;
        if (PAR) bits = {d, (^d) ^ badpar};
        else bits = {1'b0, d};
        n = FL + delta;
        for (int i = 0; i < n; i++) begin
            serialEn = 1'b1;
            serialIn = (i < FL) ? bits[FL-1-i] : 1'b0;
            step();
        end
        serialEn = 1'b0;
        serialIn = 1'b0;
    endtask

    vec_t       vecs[8];
    logic [4:0] model_cfg;

    initial begin
        vecs[0] = '{5'h00, -1, 1'b0, 1'b0};
        vecs[1] = '{5'h00, 2, 1'b0, 1'b0};
        vecs[2] = '{5'h14, 0, 1'b0, 1'b1};
        vecs[3] = '{5'h0A, 0, 1'b0, 1'b1};
        vecs[4] = '{5'h03, 0, 1'b0, 1'b1};
        vecs[5] = '{5'h14, 0, 1'b1, !PAR};
        vecs[6] = '{5'h1F, -FL, 1'b0, 1'b0};
        vecs[7] = '{5'h15, 0, 1'b0, 1'b1};

        // Reset held two cycles
        step();
        step();
        check("rst_cfg", 32'(cfg), 32'h1F);
        check("rst_sout", 32'(serialOut), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_upd", 32'(updated), 32'd0);
        check("rst_ferr", 32'(frameError), 32'd0);
        reset = 1'b0;
        model_cfg = 5'h1F;

        // applyReady while idle does nothing
        applyReady = 1'b1;
        step();
        applyReady = 1'b0;
        step();
        check("idle_apply_upd", 32'(updated), 32'd0);
        check("idle_apply_cfg", 32'(cfg), 32'(model_cfg));

        for (int v = 0; v < 8; v++) begin
            shift_frame(vecs[v].data, vecs[v].delta, vecs[v].badpar);
            latch = 1'b1;
            step();
            latch = 1'b0;
            if (vecs[v].exp_ok) begin
                check("acc_busy", 32'(busy), 32'd1);
                check("acc_upd_early", 32'(updated), 32'd0);
                check("acc_cfg_early", 32'(cfg), 32'(model_cfg));
                applyReady = 1'b1;
                step();
                applyReady = 1'b0;
                model_cfg = vecs[v].data;
                check("acc_cfg", 32'(cfg), 32'(model_cfg));
                check("acc_upd", 32'(updated), 32'd1);
                check("acc_busy_clr", 32'(busy), 32'd0);
                check("acc_ferr", 32'(frameError), 32'd0);
                step();
                check("acc_upd_pulse", 32'(updated), 32'd0);
            end else begin
                check("rej_ferr", 32'(frameError), 32'd1);
                check("rej_busy", 32'(busy), 32'd0);
                check("rej_cfg", 32'(cfg), 32'(model_cfg));
                check("rej_sout", 32'(serialOut), 32'(model_cfg[4]));
                check("rej_upd", 32'(updated), 32'd0);
                step();
                check("rej_ferr_pulse", 32'(frameError), 32'd0);
            end
        end

        // Deferred apply: shadow and config frozen while pending
        shift_frame(5'h0A, 0, 1'b0);
        latch = 1'b1;
        step();
        latch = 1'b0;
        for (int c = 0; c < 10; c++) begin
            serialEn = 1'b1;
            serialIn = 1'b1;
            latch = c[0];
            step();
            check("def_cfg", 32'(cfg), 32'(model_cfg));
            check("def_sout", 32'(serialOut), 32'd0);
            check("def_busy", 32'(busy), 32'd1);
            check("def_ferr", 32'(frameError), 32'd0);
        end
        serialEn = 1'b0;
        serialIn = 1'b0;
        latch = 1'b0;
        applyReady = 1'b1;
        step();
        applyReady = 1'b0;
        model_cfg = 5'h0A;
        check("def_cfg_apply", 32'(cfg), 32'h0A);
        check("def_upd", 32'(updated), 32'd1);
        step();
        check("def_upd_pulse", 32'(updated), 32'd0);

        // Reset while pending aborts the commit
        shift_frame(5'h05, 0, 1'b0);
        latch = 1'b1;
        step();
        latch = 1'b0;
        check("rp_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        applyReady = 1'b1;
        step();
        check("rp_cfg", 32'(cfg), 32'h1F);
        check("rp_upd", 32'(updated), 32'd0);
        check("rp_busy_clr", 32'(busy), 32'd0);
        reset = 1'b0;
        step();
        applyReady = 1'b0;
        check("rp_upd_after", 32'(updated), 32'd0);
        check("rp_cfg_after", 32'(cfg), 32'h1F);
        check("rp_sout", 32'(serialOut), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
